// File: rtl/unlock_pkg.sv
// Shared constants, key/flag tables and state encoding
// for the unlock sequencer and its testbench-facing defaults.
package unlock_pkg;

    localparam int DEF_NUM_WORDS   = 4;
    localparam int DEF_FLAG_WORDS  = 2;
    localparam int DEF_MAX_FAILS   = 3;
    localparam int DEF_LOCK_CYCLES = 1024;

    localparam logic [31:0] KEY_SEQ [DEF_NUM_WORDS] = '{
        32'h4C6F7452,
        32'h0BADC0DE,
        32'hDEADBEEF,
        32'h13371337
    };

    localparam logic [31:0] FLAG_SEQ [DEF_FLAG_WORDS] = '{
        32'h00464C45,
        32'h47217E00
    };

    typedef enum logic [1:0] {
        S_COLLECT,
        S_EMIT,
        S_LOCKOUT,
        S_LOCKED
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unlock_sequencer_if.sv
// Key-input and flag-output handshake bundle.
// master = host/consumer side, slave = sequencer.
interface unlock_sequencer_if;

    logic [31:0] key;
    logic        key_valid;
    logic        key_ready;
    logic        abort;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output key,
        output key_valid,
        output abort,
        output data_ready,
        input  key_ready,
        input  data,
        input  data_valid
    );

    modport slave (
        input  key,
        input  key_valid,
        input  abort,
        input  data_ready,
        output key_ready,
        output data,
        output data_valid
    );

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter that holds at zero;
// done is high while the count is zero.
module lockout_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] value_o,
    output logic         done_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Load has priority; otherwise count down, stopping at zero.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign done_o  = (value_q == '0);

endmodule

// File: rtl/unlock_sequencer.sv
// Key-check / flag-release controller: collects key words,
// releases the flag on a match, rate-limits and locks on failures.
module unlock_sequencer
    import unlock_pkg::*;
#(
    parameter int NUM_WORDS   = DEF_NUM_WORDS,
    parameter int FLAG_WORDS  = DEF_FLAG_WORDS,
    parameter int MAX_FAILS   = DEF_MAX_FAILS,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    unlock_sequencer_if.slave        bus,
    output logic                     busy,
    output logic                     locked,
    output logic [3:0]               fail_count
);

    localparam int IDX_W  = clog2_min1(NUM_WORDS);
    localparam int FIDX_W = clog2_min1(FLAG_WORDS);
    localparam int CNT_W  = clog2_min1(LOCK_CYCLES);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [FIDX_W-1:0] LAST_F   = FIDX_W'(FLAG_WORDS - 1);
    localparam logic [3:0]        MAX_F    = 4'(MAX_FAILS);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(LOCK_CYCLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mism_q, mism_d;
    logic [3:0]          fail_q, fail_d;
    logic [31:0]         data_q, data_d;
    logic                dv_q, dv_d;
    logic [FIDX_W-1:0]   fidx_q, fidx_d;

    logic                key_rdy;
    logic                word_bad;
    logic [3:0]          fail_inc;
    logic [FIDX_W-1:0]   fidx_nxt;
    logic                tmr_load;
    logic                tmr_en;
    logic [CNT_W-1:0]    tmr_value;
    logic                tmr_done;

    lockout_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (LOAD_VAL),
        .en_i       (tmr_en),
        .value_o    (tmr_value),
        .done_o     (tmr_done)
    );

    // Next-state, word compare, fail accounting and flag sequencing.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        data_d   = data_q;
        dv_d     = dv_q;
        fidx_d   = fidx_q;
        key_rdy  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        word_bad = (bus.key != KEY_SEQ[idx_q]);
        fail_inc = fail_q + 4'd1;
        fidx_nxt = fidx_q + 1'b1;

        unique case (state_q)
            S_COLLECT: begin
                key_rdy = ~bus.abort;
                if (bus.abort) begin
                    idx_d  = '0;
                    mism_d = 1'b0;
                end else if (bus.key_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        mism_d = 1'b0;
                        if (mism_q || word_bad) begin
                            fail_d = fail_inc;
                            if (fail_inc == MAX_F) begin
                                state_d = S_LOCKED;
                            end else begin
                                state_d  = S_LOCKOUT;
                                tmr_load = 1'b1;
                            end
                        end else begin
                            fail_d  = '0;
                            state_d = S_EMIT;
                            data_d  = FLAG_SEQ[0];
                            dv_d    = 1'b1;
                            fidx_d  = '0;
                        end
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        mism_d = mism_q | word_bad;
                    end
                end
            end
            S_EMIT: begin
                if (dv_q && bus.data_ready) begin
                    if (fidx_q == LAST_F) begin
                        dv_d    = 1'b0;
                        data_d  = '0;
                        idx_d   = '0;
                        mism_d  = 1'b0;
                        state_d = S_COLLECT;
                    end else begin
                        fidx_d = fidx_nxt;
                        data_d = FLAG_SEQ[fidx_nxt];
                    end
                end
            end
            S_LOCKOUT: begin
                tmr_en = (tmr_value != '0);
                if (tmr_done) begin
                    state_d = S_COLLECT;
                end
            end
            S_LOCKED: begin
                state_d = S_LOCKED;
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            fail_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            fail_q  <= fail_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fidx_q  <= fidx_d;
        end
    end

    assign bus.key_ready  = key_rdy;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign busy           = (state_q == S_EMIT) || (state_q == S_LOCKOUT);
    assign locked         = (state_q == S_LOCKED);
    assign fail_count     = fail_q;

endmodule
